carfield_xilinx_rst_seq: RTL and testbench

FPGA reset and boot-mode sequencer that sits directly upstream of the Carfield SoC in the Xilinx top level. It produces the SoC power-on reset (`pwr_on_rst_ni`) and the latched host/safety boot modes. Release is gated on clock-wizard lock, DDR calibration, a debounced board reset button and the VIO reset. Every restart and hold-off is counted for debug.

---
 rtl/carfield_xilinx_rst_seq.sv | 205 ++++++++++++++++++++
 tb/tb_carfield_xilinx_rst_seq.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/carfield_xilinx_rst_seq.sv
// carfield_xilinx_rst_seq
// ----------------------------------------------------------------------------
// FPGA reset and boot-mode sequencer for the Carfield SoC in the Xilinx top
// level. Drives the SoC power-on reset and latches the host and safety boot
// modes at the moment that reset is released.
//
// Release requires all of the following:
//   - the clock wizard is locked
//   - DDR calibration is done (when UseDdrCalib is set)
//   - the debounced board button is not pressed
//   - no VIO reset request is active
// Once those hold, the reset is kept asserted for HoldCycles more cycles.
// Every drop out of RUN is counted so a debugger can see how many restarts
// happened.
//
// Parameters:
//   HoldCycles      cycles soc_rst_no stays low once lock and calibration are
//                   good (>= 1)
//   DebounceCycles  consecutive high cycles before the button counts (>= 1)
//   UseDdrCalib     1 gates release on ddr_calib_done_i, 0 ignores it
//
// Ports:
//   clk_i               SoC clock
//   rst_i               synchronous active-high reset
//   clk_locked_i        clock-wizard lock (async, 2-flop synchronized)
//   ddr_calib_done_i    DDR calibration done (async, 2-flop synchronized)
//   ext_rst_i           board reset button (async, synchronized + debounced)
//   vio_rst_i           VIO reset request (already synchronous to clk_i)
//   boot_mode_i         host boot-mode switches (async, 2-flop synchronized)
//   boot_mode_safety_i  safety boot-mode switches (async, 2-flop synchronized)
//   soc_rst_no          SoC reset, active-low
//   boot_mode_o         host boot mode latched at release
//   boot_mode_safety_o  safety boot mode latched at release
//   rst_cnt_o           restarts since rst_i, saturating at 255
//   state_o             current sequencer state
// ----------------------------------------------------------------------------
module carfield_xilinx_rst_seq #(
  parameter int unsigned HoldCycles     = 1024,
  parameter int unsigned DebounceCycles = 2000,
  parameter bit          UseDdrCalib    = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clk_locked_i,
  input  logic       ddr_calib_done_i,
  input  logic       ext_rst_i,
  input  logic       vio_rst_i,
  input  logic [1:0] boot_mode_i,
  input  logic [1:0] boot_mode_safety_i,
  output logic       soc_rst_no,
  output logic [1:0] boot_mode_o,
  output logic [1:0] boot_mode_safety_o,
  output logic [7:0] rst_cnt_o,
  output logic [1:0] state_o
);

  localparam int unsigned HoldW = $clog2(HoldCycles + 1);
  localparam int unsigned DbW   = $clog2(DebounceCycles + 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HoldCycles - 1);
  localparam logic [DbW-1:0]   DbMax    = DbW'(DebounceCycles);

  typedef enum logic [1:0] {
    WAIT_LOCK  = 2'd0,
    WAIT_CALIB = 2'd1,
    HOLD       = 2'd2,
    RUN        = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic       lock_meta, lock_s;
  logic       calib_meta, calib_s;
  logic       ext_meta, ext_s;
  logic [1:0] bm_meta, bm_s;
  logic [1:0] bms_meta, bms_s;

  logic [DbW-1:0]   db_cnt;
  logic [HoldW-1:0] hold_cnt;
  logic             ext_db;
  logic             calib_ok;
  logic             restart;

  // Two-flop synchronizers for every asynchronous board-level input. The
  // second stage is the only one the rest of the design looks at.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_meta  <= 1'b0;
      lock_s     <= 1'b0;
      calib_meta <= 1'b0;
      calib_s    <= 1'b0;
      ext_meta   <= 1'b0;
      ext_s      <= 1'b0;
      bm_meta    <= 2'b00;
      bm_s       <= 2'b00;
      bms_meta   <= 2'b00;
      bms_s      <= 2'b00;
    end else begin
      lock_meta  <= clk_locked_i;
      lock_s     <= lock_meta;
      calib_meta <= ddr_calib_done_i;
      calib_s    <= calib_meta;
      ext_meta   <= ext_rst_i;
      ext_s      <= ext_meta;
      bm_meta    <= boot_mode_i;
      bm_s       <= bm_meta;
      bms_meta   <= boot_mode_safety_i;
      bms_s      <= bms_meta;
    end
  end

  // Button debounce: count consecutive high samples and saturate. Only the
  // press is debounced; letting go clears the counter on the next edge so
  // the restart request drops right away.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      db_cnt <= '0;
    end else if (!ext_s) begin
      db_cnt <= '0;
    end else if (db_cnt != DbMax) begin
      db_cnt <= db_cnt + DbW'(1);
    end
  end

  assign ext_db   = (db_cnt == DbMax);
  assign calib_ok = UseDdrCalib ? calib_s : 1'b1;
  assign restart  = ext_db | vio_rst_i;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= WAIT_LOCK;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A restart request beats everything else. Lock loss is
  // checked before calibration so a simultaneous change of both always goes
  // back to WAIT_LOCK.
  always_comb begin
    state_d = state_q;
    if (restart) begin
      state_d = WAIT_LOCK;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          if (lock_s) state_d = UseDdrCalib ? WAIT_CALIB : HOLD;
        end
        WAIT_CALIB: begin
          if (!lock_s)      state_d = WAIT_LOCK;
          else if (calib_s) state_d = HOLD;
        end
        HOLD: begin
          if (!lock_s || !calib_ok)     state_d = WAIT_LOCK;
          else if (hold_cnt == HoldLast) state_d = RUN;
        end
        RUN: begin
          if (!lock_s || !calib_ok) state_d = WAIT_LOCK;
        end
        default: state_d = WAIT_LOCK;
      endcase
    end
  end

  // Hold counter only runs while in HOLD. Outside HOLD it sits at zero, so
  // every entry into HOLD starts a fresh full-length hold.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_cnt <= '0;
    end else if (state_q != HOLD) begin
      hold_cnt <= '0;
    end else begin
      hold_cnt <= hold_cnt + HoldW'(1);
    end
  end

  // Boot modes are captured on the HOLD->RUN edge only. That way the SoC
  // sees stable straps for its whole run, whatever the switches do.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      boot_mode_o        <= 2'b00;
      boot_mode_safety_o <= 2'b00;
    end else if (state_q == HOLD && state_d == RUN) begin
      boot_mode_o        <= bm_s;
      boot_mode_safety_o <= bms_s;
    end
  end

  // Restart counter for debug: one increment per exit from RUN. It
  // saturates so a flapping lock cannot wrap it back to a small value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rst_cnt_o <= 8'd0;
    end else if (state_q == RUN && state_d != RUN && rst_cnt_o != 8'hFF) begin
      rst_cnt_o <= rst_cnt_o + 8'd1;
    end
  end

  // Outputs decode the state register only, so the SoC reset cannot glitch.
  always_comb begin
    soc_rst_no = (state_q == RUN);
    state_o    = state_q;
  end

endmodule

// File: tb/tb_carfield_xilinx_rst_seq.sv
// tb_carfield_xilinx_rst_seq
// ----------------------------------------------------------------------------
// Self-checking bench for carfield_xilinx_rst_seq. Two instances share the
// stimulus:
//   dut_calib    UseDdrCalib = 1
//   dut_nocalib  UseDdrCalib = 0, with its calibration input tied low
// A table of hand-computed vectors covers cold boot, lock loss, the VIO
// pulse and reset mid-HOLD. Hand-written sequences cover debounce, boot-mode
// latching and counter saturation. A random phase follows. Throughout, a
// cycle-level behavioural model checks every output of both instances.
// ----------------------------------------------------------------------------
module tb_carfield_xilinx_rst_seq;

  localparam int H = 16;
  localparam int D = 8;

  logic clk;
  logic rst, lock, calib, ext, vio;
  logic [1:0] bm, bms;

  logic [1:0] rn;
  logic [1:0] st   [2];
  logic [7:0] cnt  [2];
  logic [1:0] bmo  [2];
  logic [1:0] bmso [2];

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  carfield_xilinx_rst_seq #(.HoldCycles(H), .DebounceCycles(D), .UseDdrCalib(1'b1)) dut_calib (
    .clk_i(clk), .rst_i(rst), .clk_locked_i(lock), .ddr_calib_done_i(calib),
    .ext_rst_i(ext), .vio_rst_i(vio), .boot_mode_i(bm), .boot_mode_safety_i(bms),
    .soc_rst_no(rn[0]), .boot_mode_o(bmo[0]), .boot_mode_safety_o(bmso[0]),
    .rst_cnt_o(cnt[0]), .state_o(st[0])
  );

  carfield_xilinx_rst_seq #(.HoldCycles(H), .DebounceCycles(D), .UseDdrCalib(1'b0)) dut_nocalib (
    .clk_i(clk), .rst_i(rst), .clk_locked_i(lock), .ddr_calib_done_i(1'b0),
    .ext_rst_i(ext), .vio_rst_i(vio), .boot_mode_i(bm), .boot_mode_safety_i(bms),
    .soc_rst_no(rn[1]), .boot_mode_o(bmo[1]), .boot_mode_safety_o(bmso[1]),
    .rst_cnt_o(cnt[1]), .state_o(st[1])
  );

  // 10-time-unit clock; inputs change and outputs are sampled on the falling edge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural reference model.
  // Synchronizers are modelled as 2-deep delay lines and the debouncer as a
  // run length of high samples. The release progress is a single step
  // counter per instance:
  //   0            waiting for lock
  //   1            waiting for calibration
  //   2 .. H+1     hold cycles elapsed (+2)
  //   m_up         the SoC has been released
  // ---------------------------------------------------------------------------
  logic [1:0] ms_lock  = '0, ms_calib = '0, ms_ext = '0;
  logic [1:0] ms_bm [2];
  logic [1:0] ms_bms [2];
  int         m_high = 0;
  bit         m_up   [2];
  int         m_step [2];
  int         m_cnt  [2];
  logic [1:0] m_bm   [2];
  logic [1:0] m_bms  [2];

  task automatic modelEdge();
    bit restart, calib_ok;
    if (rst) begin
      ms_lock = '0; ms_calib = '0; ms_ext = '0; m_high = 0;
      for (int k = 0; k < 2; k++) begin
        ms_bm[k] = '0; ms_bms[k] = '0;
        m_up[k] = 0; m_step[k] = 0; m_cnt[k] = 0; m_bm[k] = '0; m_bms[k] = '0;
      end
    end else begin
      restart = (m_high == D) || (vio == 1'b1);
      for (int k = 0; k < 2; k++) begin
        calib_ok = (k == 1) ? 1'b1 : ms_calib[1];
        if (m_up[k]) begin
          if (restart || !ms_lock[1] || !calib_ok) begin
            m_up[k] = 0;
            m_step[k] = 0;
            if (m_cnt[k] < 255) m_cnt[k]++;
          end
        end else if (restart) begin
          m_step[k] = 0;
        end else if (m_step[k] == 0) begin
          if (ms_lock[1]) m_step[k] = (k == 1) ? 2 : 1;
        end else if (m_step[k] == 1) begin
          if (!ms_lock[1]) m_step[k] = 0;
          else if (ms_calib[1]) m_step[k] = 2;
        end else begin
          if (!ms_lock[1] || !calib_ok) m_step[k] = 0;
          else if (m_step[k] - 2 == H - 1) begin
            m_up[k]  = 1;
            m_bm[k]  = ms_bm[1];
            m_bms[k] = ms_bms[1];
          end else m_step[k]++;
        end
      end
      m_high = ms_ext[1] ? ((m_high < D) ? m_high + 1 : D) : 0;
      ms_lock  = {ms_lock[0], lock};
      ms_calib = {ms_calib[0], calib};
      ms_ext   = {ms_ext[0], ext};
      ms_bm[1]  = ms_bm[0];  ms_bm[0]  = bm;
      ms_bms[1] = ms_bms[0]; ms_bms[0] = bms;
    end
  endtask

  // The model steps just after each rising edge, using the inputs that were
  // stable across that edge.
  initial forever begin
    @(posedge clk);
    #1;
    modelEdge();
  end

  // Continuous comparison of both instances against the model.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        checkOutput($sformatf("model.rst_n[%0d]", k), rn[k], m_up[k]);
        checkOutput($sformatf("model.state[%0d]", k), st[k],
                    m_up[k] ? 3 : (m_step[k] == 0 ? 0 : (m_step[k] == 1 ? 1 : 2)));
        checkOutput($sformatf("model.rst_cnt[%0d]", k), cnt[k], m_cnt[k]);
        checkOutput($sformatf("model.boot_mode[%0d]", k), bmo[k], m_bm[k]);
        checkOutput($sformatf("model.boot_safety[%0d]", k), bmso[k], m_bms[k]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed vector table, expected values worked out by hand.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic       rst, lock, calib, vio;
    logic [1:0] bm, bms;
    int         n;
    logic       exp_rn;
    logic [1:0] exp_st;
    int         exp_cnt;
    logic [1:0] exp_bm, exp_bms;
    logic       exp_rn2;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic applyStimulus(input vec_t v);
    rst = v.rst; lock = v.lock; calib = v.calib; vio = v.vio; bm = v.bm; bms = v.bms;
    cycles(v.n);
    checkOutput({v.name, ".rst_n"},    rn[0],   v.exp_rn);
    checkOutput({v.name, ".state"},    st[0],   v.exp_st);
    checkOutput({v.name, ".rst_cnt"},  cnt[0],  v.exp_cnt);
    checkOutput({v.name, ".boot"},     bmo[0],  v.exp_bm);
    checkOutput({v.name, ".boot_s"},   bmso[0], v.exp_bms);
    checkOutput({v.name, ".rst_n_nc"}, rn[1],   v.exp_rn2);
  endtask

  task automatic waitRelease(input string name);
    int waited = 0;
    while (rn[0] !== 1'b1 && waited < 60) begin
      cycles(1);
      waited++;
    end
    if (rn[0] !== 1'b1) checkOutput({name, ".timeout"}, rn[0], 1);
  endtask

  initial begin
    int unsigned r;
    rst = 1'b1; lock = 1'b0; calib = 1'b0; ext = 1'b0; vio = 1'b0; bm = 2'b00; bms = 2'b00;

    //                rst lock cal vio  bm     bms    n   rn st   cnt bm     bms    rn2
    vecs.push_back('{1, 1, 1, 0, 2'b10, 2'b01, 4,  0, 2'd0, 0, 2'b00, 2'b00, 0, "reset"});
    vecs.push_back('{0, 1, 1, 0, 2'b10, 2'b01, 2,  0, 2'd0, 0, 2'b00, 2'b00, 0, "sync_latency"});
    vecs.push_back('{0, 1, 1, 0, 2'b10, 2'b01, 1,  0, 2'd1, 0, 2'b00, 2'b00, 0, "wait_calib"});
    vecs.push_back('{0, 1, 1, 0, 2'b10, 2'b01, 1,  0, 2'd2, 0, 2'b00, 2'b00, 0, "hold_entry"});
    vecs.push_back('{0, 1, 1, 0, 2'b10, 2'b01, 15, 0, 2'd2, 0, 2'b00, 2'b00, 1, "hold_last"});
    vecs.push_back('{0, 1, 1, 0, 2'b10, 2'b01, 1,  1, 2'd3, 0, 2'b10, 2'b01, 1, "cold_release"});
    vecs.push_back('{1, 1, 1, 0, 2'b10, 2'b01, 1,  0, 2'd0, 0, 2'b00, 2'b00, 0, "reset_in_run"});
    vecs.push_back('{0, 1, 1, 0, 2'b10, 2'b01, 3,  0, 2'd1, 0, 2'b00, 2'b00, 0, "boot2_calib"});
    vecs.push_back('{0, 1, 1, 0, 2'b10, 2'b01, 1,  0, 2'd2, 0, 2'b00, 2'b00, 0, "boot2_hold"});
    vecs.push_back('{0, 1, 1, 0, 2'b10, 2'b01, 5,  0, 2'd2, 0, 2'b00, 2'b00, 0, "hold_cycle8"});
    vecs.push_back('{0, 0, 1, 0, 2'b10, 2'b01, 2,  0, 2'd2, 0, 2'b00, 2'b00, 0, "lock_drop_sync"});
    vecs.push_back('{0, 0, 1, 0, 2'b10, 2'b01, 1,  0, 2'd0, 0, 2'b00, 2'b00, 0, "lock_loss"});
    vecs.push_back('{0, 1, 1, 0, 2'b10, 2'b01, 2,  0, 2'd0, 0, 2'b00, 2'b00, 0, "relock_sync"});
    vecs.push_back('{0, 1, 1, 0, 2'b10, 2'b01, 1,  0, 2'd1, 0, 2'b00, 2'b00, 0, "relock_calib"});
    vecs.push_back('{0, 1, 1, 0, 2'b10, 2'b01, 1,  0, 2'd2, 0, 2'b00, 2'b00, 0, "relock_hold"});
    vecs.push_back('{0, 1, 1, 0, 2'b10, 2'b01, 15, 0, 2'd2, 0, 2'b00, 2'b00, 1, "relock_hold_last"});
    vecs.push_back('{0, 1, 1, 0, 2'b10, 2'b01, 1,  1, 2'd3, 0, 2'b10, 2'b01, 1, "relock_release"});
    vecs.push_back('{0, 1, 1, 1, 2'b10, 2'b01, 1,  0, 2'd0, 1, 2'b10, 2'b01, 0, "vio_pulse"});
    vecs.push_back('{0, 1, 1, 0, 2'b10, 2'b01, 4,  0, 2'd2, 1, 2'b10, 2'b01, 0, "vio_rehold"});
    vecs.push_back('{1, 1, 1, 0, 2'b10, 2'b01, 1,  0, 2'd0, 0, 2'b00, 2'b00, 0, "reset_mid_hold"});

    @(negedge clk);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      if (i == 0) chk_en = 1'b1;
    end

    // Debounce: a short glitch is ignored, a long press restarts the SoC.
    rst = 1'b0; lock = 1'b1; calib = 1'b1; bm = 2'b01; bms = 2'b10;
    waitRelease("db_boot");
    ext = 1'b1;
    cycles(5);
    ext = 1'b0;
    cycles(10);
    checkOutput("glitch.state", st[0], 3);
    checkOutput("glitch.rst_cnt", cnt[0], 0);
    ext = 1'b1;
    cycles(10);
    checkOutput("press.before_fall", rn[0], 1);
    cycles(1);
    checkOutput("press.fall", rn[0], 0);
    checkOutput("press.rst_cnt", cnt[0], 1);
    cycles(9);
    ext = 1'b0;
    cycles(19);
    checkOutput("rerelease.nc_before", rn[1], 0);
    cycles(1);
    checkOutput("rerelease.before", rn[0], 0);
    checkOutput("rerelease.nc", rn[1], 1);
    cycles(1);
    checkOutput("rerelease.rst_n", rn[0], 1);
    checkOutput("rerelease.boot", bmo[0], 2'b01);

    // Boot-mode latching: switch changes in RUN are ignored until a restart.
    bm = 2'b11;
    cycles(10);
    checkOutput("latch.hold", bmo[0], 2'b01);
    checkOutput("latch.hold_s", bmso[0], 2'b10);
    vio = 1'b1;
    cycles(1);
    checkOutput("latch.vio_fall", rn[0], 0);
    vio = 1'b0;
    waitRelease("latch_release");
    checkOutput("latch.new", bmo[0], 2'b11);

    // Restart counter saturation through repeated VIO pulses.
    for (int i = 0; i < 300; i++) begin
      waitRelease("sat_release");
      vio = 1'b1;
      cycles(1);
      checkOutput("sat.vio_fall", rn[0], 0);
      vio = 1'b0;
    end
    cycles(2);
    checkOutput("sat.rst_cnt", cnt[0], 255);
    checkOutput("sat.rst_cnt_nc", cnt[1], 255);

    // Random phase, checked against the model only.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(999);
      rst = (r < 3);
      if (lock) lock = ($urandom_range(99) >= 1);
      else      lock = ($urandom_range(99) < 20);
      if (calib) calib = ($urandom_range(99) >= 1);
      else       calib = ($urandom_range(99) < 20);
      if (ext) ext = ($urandom_range(99) >= 10);
      else     ext = ($urandom_range(99) < 2);
      vio = ($urandom_range(99) < 1);
      if ($urandom_range(9) == 0) bm  = 2'($urandom_range(3));
      if ($urandom_range(9) == 0) bms = 2'($urandom_range(3));
      cycles(1);
    end

    rst = 1'b0; vio = 1'b0; ext = 1'b0;
    cycles(2);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
